// File: rtl/bcast_fanout_unit.sv
// bcast_fanout_unit: replicates one downward broadcast flit into one copy per binomial-tree child.
// Latency: FIFO pop (rd_en) in cycle T presents the first copy in T+1; one copy per cycle when out_ready stays high.
// Backpressure: each copy is held stable while out_ready is low; the FIFO is not popped again until one DRAIN cycle after the last accept.
//
// Ports:
//   clk, rst (async, active-low)   single clock domain
//   packet_in / buf_empty / rd_en  first-word-fall-through FIFO head {children, flit}, pop is combinational
//   valid_out / out_ready          registered output copy handshake, out_packet is the copy
//   busy                           high whenever the FSM is not IDLE
//   done                           single-cycle pulse on acceptance of the final copy of a packet
// Optional build macro: BCAST_SELF_COPY_EN -- non-leaf packets also emit a local-delivery copy
//   (dst = own coordinates) ahead of the child copies.
module bcast_fanout_unit #(
  parameter logic [2:0]  rank_z       = 3'b0,
  parameter logic [2:0]  rank_y       = 3'b0,
  parameter logic [2:0]  rank_x       = 3'b0,
  parameter int unsigned lg_numprocs  = 3,
  parameter int unsigned PayloadWidth = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [PayloadWidth+50+lg_numprocs-1:0]  packet_in,
  input  logic                                    buf_empty,
  output logic                                    rd_en,
  input  logic                                    out_ready,
  output logic                                    valid_out,
  output logic [PayloadWidth+49:0]                out_packet,
  output logic                                    busy,
  output logic                                    done
);

  localparam int unsigned FlitWidth     = PayloadWidth + 50;
  localparam int unsigned ChildrenWidth = lg_numprocs;
  // contextId, tag, algtype, op and payload sit below the rank field and pass through untouched.
  localparam int unsigned LowWidth      = PayloadWidth + 22;
  localparam int unsigned ValidBit      = FlitWidth - 1;

  // Coordinates packed {z,y,x} are the rank itself, so dst/src fields are ranks zero-extended to 9 bits.
  localparam logic [8:0] Coords   = {rank_z, rank_y, rank_x};
  localparam logic [8:0] RankMask = 9'((10'd1 << lg_numprocs) - 10'd1);
  localparam logic [8:0] MyRank   = Coords & RankMask;

  // Number of subtrees below this node: trailing zeros of the rank, or the full tree depth at the root.
  function automatic logic [3:0] max_k_f(input logic [8:0] r);
    logic [3:0] k;
    k = 4'(lg_numprocs);
    for (int i = int'(lg_numprocs) - 1; i >= 0; i--) begin
      if (r[i]) k = 4'(i);
    end
    return k;
  endfunction

  localparam logic [3:0] MaxK = max_k_f(MyRank);

  // k is always below the trailing-zero count, so the add never carries into existing rank bits.
  function automatic logic [8:0] child_f(input logic [3:0] k);
    return MyRank + (9'd1 << k);
  endfunction

  function automatic logic [FlitWidth-1:0] mk_flit(input logic [8:0] dst, input logic [LowWidth-1:0] low);
    return {1'b1, dst, Coords, MyRank, low};
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [FlitWidth-1:0]   out_q, out_d;
  logic [LowWidth-1:0]    low_q, low_d;
  logic [3:0]             k_q, k_d;     // subtree index of the next copy to present
  logic [3:0]             rem_q, rem_d; // copies still to present after the current one

  logic [ChildrenWidth-1:0] children;
  logic [LowWidth-1:0]      head_low;
  logic [3:0]               kcnt;
  logic                     unused_hdr;

  assign children   = packet_in[FlitWidth +: ChildrenWidth];
  assign head_low   = packet_in[LowWidth-1:0];
  // Incoming dst/src/rank are regenerated per copy, so they are intentionally dropped.
  assign unused_hdr = ^packet_in[LowWidth +: 27];

  // Children beyond what this rank can own are clamped rather than flagged.
  always_comb begin
    kcnt = 4'(children);
    if (32'(children) > 32'(MaxK)) kcnt = MaxK;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    low_d   = low_q;
    k_d     = k_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        rd_en = !buf_empty;
        // A popped head with its valid bit clear is consumed and dropped without output.
        if (!buf_empty && packet_in[ValidBit]) begin
          low_d   = head_low;
          state_d = SEND;
          if (kcnt == 4'd0) begin
            out_d = mk_flit(MyRank, head_low);
            k_d   = 4'd0;
            rem_d = 4'd0;
          end else begin
`ifdef BCAST_SELF_COPY_EN
            out_d = mk_flit(MyRank, head_low);
            k_d   = kcnt - 4'd1;
            rem_d = kcnt;
`else
            out_d = mk_flit(child_f(kcnt - 4'd1), head_low);
            k_d   = kcnt - 4'd2;
            rem_d = kcnt - 4'd1;
`endif
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (rem_q == 4'd0) begin
            done    = 1'b1;
            state_d = DRAIN;
          end else begin
            out_d = mk_flit(child_f(k_q), low_q);
            k_d   = k_q - 4'd1;
            rem_d = rem_q - 4'd1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      low_q   <= '0;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      low_q   <= low_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end

  assign valid_out  = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign out_packet = out_q;

endmodule
